// File: rtl/bch_chien_search.sv
// Chien search: sweeps sigma(alpha^i) for i = 0..N-1 and streams per-position root flags.
// Optional early termination when the root count reaches err_count: BCH_CHIEN_EARLY_TERM_EN.
module bch_chien_search #(
    parameter int unsigned M         = 4,
    parameter int unsigned T         = 2,
    parameter logic [M:0]  PRIM_POLY = 5'b10011,
    parameter int unsigned ERR_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 ready,
    input  logic [(T+1)*M-1:0]   sigma,
    input  logic [ERR_W-1:0]     err_count,
    output logic                 err_valid,
    output logic                 err,
    output logic [M-1:0]         err_index,
    output logic                 last,
    output logic                 done,
    output logic                 fail,
    input  logic                 ack_done
);

    localparam int unsigned    N         = (1 << M) - 1;
    localparam logic [M-1:0]   LAST_IDX  = M'(N - 1);
    localparam logic [ERR_W-1:0] FOUND_MAX = '1;
    localparam logic [ERR_W-1:0] T_CNT     = ERR_W'(T);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Multiply by alpha: shift left and reduce by the primitive polynomial.
    function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
        return {x[M-2:0], 1'b0} ^ (x[M-1] ? PRIM_POLY[M-1:0] : '0);
    endfunction

    // Constant multiply by alpha^k; k is elaboration-constant so this folds to an XOR net.
    function automatic logic [M-1:0] mul_alpha_pow(input logic [M-1:0] x, input int unsigned k);
        logic [M-1:0] r;
        r = x;
        for (int unsigned j = 0; j < T; j++) begin
            if (j < k) r = mul_alpha(r);
        end
        return r;
    endfunction

    state_e                 state_q, state_d;
    logic [T:0][M-1:0]      term_q, term_d;
    logic [M-1:0]           idx_q, idx_d;
    logic [ERR_W-1:0]       found_q, found_d;
    logic [ERR_W-1:0]       ec_q, ec_d;
    logic                   sig0_zero_q, sig0_zero_d;

    logic [M-1:0]           eval;
    logic                   root;
    logic [ERR_W-1:0]       found_inc;

    always_comb begin
        eval = '0;
        for (int unsigned k = 0; k <= T; k++) begin
            eval = eval ^ term_q[k];
        end
    end

    assign root      = (eval == '0);
    assign found_inc = (found_q == FOUND_MAX) ? found_q : found_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        term_d      = term_q;
        idx_d       = idx_q;
        found_d     = found_q;
        ec_d        = ec_q;
        sig0_zero_d = sig0_zero_q;
        ready       = 1'b0;
        err_valid   = 1'b0;
        err         = 1'b0;
        err_index   = '0;
        last        = 1'b0;
        done        = 1'b0;
        fail        = 1'b0;

        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) begin
                    term_d      = sigma;
                    idx_d       = '0;
                    found_d     = '0;
                    ec_d        = err_count;
                    sig0_zero_d = (sigma[M-1:0] == '0);
                    state_d     = StRun;
`ifdef BCH_CHIEN_EARLY_TERM_EN
                    if (err_count == '0) state_d = StDone;
`endif
                end
            end
            StRun: begin
                err_valid = 1'b1;
                err       = root;
                err_index = idx_q;
                last      = (idx_q == LAST_IDX);
                if (root) found_d = found_inc;
`ifdef BCH_CHIEN_EARLY_TERM_EN
                if (root && (found_inc == ec_q)) last = 1'b1;
`endif
                for (int unsigned k = 1; k <= T; k++) begin
                    term_d[k] = mul_alpha_pow(term_q[k], k);
                end
                idx_d = idx_q + 1'b1;
                if (last) state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                fail = (found_q != ec_q) | sig0_zero_q | (ec_q > T_CNT);
                if (ack_done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            term_q      <= '0;
            idx_q       <= '0;
            found_q     <= '0;
            ec_q        <= '0;
            sig0_zero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            term_q      <= term_d;
            idx_q       <= idx_d;
            found_q     <= found_d;
            ec_q        <= ec_d;
            sig0_zero_q <= sig0_zero_d;
        end
    end

endmodule

// File: tb/tb_bch_chien_search.sv
// Self-checking bench for bch_chien_search: vector table, beat scoreboard and handshake/reset
// sequences. Expectations follow BCH_CHIEN_EARLY_TERM_EN when it is defined.
module tb_bch_chien_search;

    localparam int M     = 4;
    localparam int T     = 2;
    localparam int ERR_W = 2;
    localparam int N     = 15;
    localparam int SW    = (T + 1) * M;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             ack_done = 1'b0;
    logic [SW-1:0]    sigma = '0;
    logic [ERR_W-1:0] err_count = '0;
    logic             ready, err_valid, err, last, done, fail;
    logic [M-1:0]     err_index;

    always #5 clk = ~clk;

    bch_chien_search dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ready     (ready),
        .sigma     (sigma),
        .err_count (err_count),
        .err_valid (err_valid),
        .err       (err),
        .err_index (err_index),
        .last      (last),
        .done      (done),
        .fail      (fail),
        .ack_done  (ack_done)
    );

    typedef struct {
        logic [SW-1:0]    sigma;
        logic [ERR_W-1:0] ec;
        logic [N-1:0]     roots;  // hand-derived root positions in GF(16), x^4+x+1
    } vec_t;

    typedef struct packed {
        logic [M-1:0] idx;
        logic         err;
        logic         last;
    } beat_t;

    vec_t  vecs[8];
    beat_t exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: pushes expected beats, returns beat count and expected fail.
    task automatic model(input vec_t v, output int beats, output logic efail);
        int   found;
        logic sig0z;
        logic lst;
        found = 0;
        beats = 0;
        sig0z = (v.sigma[M-1:0] == '0);
`ifdef BCH_CHIEN_EARLY_TERM_EN
        if (v.ec == 0) begin
            efail = sig0z;
            return;
        end
`endif
        for (int i = 0; i < N; i++) begin
            if (v.roots[i] && found < 3) found++;
            lst = (i == N - 1);
`ifdef BCH_CHIEN_EARLY_TERM_EN
            if (v.roots[i] && found == int'(v.ec)) lst = 1'b1;
`endif
            exp_q.push_back('{idx: M'(i), err: v.roots[i], last: lst});
            beats++;
            if (lst) break;
        end
        efail = (found != int'(v.ec)) || sig0z || (v.ec > T);
    endtask

    always @(negedge clk) begin
        if (rst_n && err_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_beat: got index %0d expected no beat", err_index);
            end else begin
                beat_t b;
                b = exp_q.pop_front();
                check("beat_index", 32'(err_index), 32'(b.idx));
                check("beat_err", 32'(err), 32'(b.err));
                check("beat_last", 32'(last), 32'(b.last));
            end
        end
    end

    task automatic run_vec(input vec_t v, input bit do_ack, output logic efail);
        int beats;
        int w;
        int cyc;
        w = 0;
        while (!ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_start", 32'(ready), 32'd1);
        model(v, beats, efail);
        start     = 1'b1;
        sigma     = v.sigma;
        err_count = v.ec;
        @(negedge clk);
        start = 1'b0;
        sigma = '0;
        err_count = '0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("done_latency", 32'(cyc), 32'(beats + 1));
        check("fail", 32'(fail), 32'(efail));
        check("beats_outstanding", 32'(exp_q.size()), 32'd0);
        if (do_ack) begin
            ack_done = 1'b1;
            @(negedge clk);
            ack_done = 1'b0;
            check("ack_ready", 32'(ready), 32'd1);
            check("ack_done_low", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic ef;
        logic ef_hold;
        int   w;

        vecs[0] = '{12'h001, 2'd0, 15'h0000};
        vecs[1] = '{12'h0F1, 2'd1, 15'h0008};
        vecs[2] = '{12'hF41, 2'd2, 15'h0006};
        vecs[3] = '{12'hF41, 2'd1, 15'h0006};
        vecs[4] = '{12'h0F1, 2'd2, 15'h0008};
        vecs[5] = '{12'h0F1, 2'd3, 15'h0008};
        vecs[6] = '{12'h0F0, 2'd1, 15'h0000};
        vecs[7] = '{12'h000, 2'd3, 15'h7FFF};

        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_valid", 32'(err_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        check("rst_fail", 32'(fail), 32'd0);
        check("rst_index", 32'(err_index), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], 1'b1, ef);
        end

        // Hold in DONE: done/fail stable, start pulses ignored.
        run_vec(vecs[3], 1'b0, ef_hold);
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            sigma = 12'h0F1;
            @(negedge clk);
            check("hold_done", 32'(done), 32'd1);
            check("hold_fail", 32'(fail), 32'(ef_hold));
            check("hold_ready", 32'(ready), 32'd0);
        end
        // Ack together with start: only the ack is taken.
        ack_done = 1'b1;
        @(negedge clk);
        ack_done = 1'b0;
        start = 1'b0;
        check("ack_start_ready", 32'(ready), 32'd1);
        check("ack_start_done", 32'(done), 32'd0);
        check("ack_start_no_beat", 32'(err_valid), 32'd0);
        run_vec(vecs[2], 1'b1, ef);

        // Reset mid-sweep at beat 7.
        begin
            int   beats;
            logic f;
            model(vecs[4], beats, f);
            start     = 1'b1;
            sigma     = vecs[4].sigma;
            err_count = vecs[4].ec;
            @(negedge clk);
            start = 1'b0;
            w = 0;
            while (!(err_valid && err_index == 4'd7) && w < 30) begin
                @(negedge clk);
                w++;
            end
            check("reached_beat7", 32'(err_index), 32'd7);
            #1;
            rst_n = 1'b0;
            #1;
            exp_q.delete();
            check("midrst_ready", 32'(ready), 32'd1);
            check("midrst_err_valid", 32'(err_valid), 32'd0);
            check("midrst_index", 32'(err_index), 32'd0);
            check("midrst_done", 32'(done), 32'd0);
            check("midrst_fail", 32'(fail), 32'd0);
            @(negedge clk);
            @(negedge clk);
            check("midrst_held_done", 32'(done), 32'd0);
            rst_n = 1'b1;
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'd0);
        end
        run_vec(vecs[4], 1'b1, ef);
        run_vec(vecs[1], 1'b1, ef);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
